if_fetch_ctrl: RTL and testbench



---
 rtl/if_fetch_ctrl_if.sv | 26 ++
 rtl/if_fetch_ctrl.sv | 67 ++++++
 tb/tb_if_fetch_ctrl.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_ctrl_if.sv
// if_fetch_ctrl_if: instruction-memory handshake, hazard inputs and pipeline controls of the fetch controller
interface if_fetch_ctrl_if #(parameter int CNT_W = 16);
    logic             imem_ready;
    logic             branch_taken;
    logic [31:0]      branch_target;
    logic             id_ex_mem_read;
    logic [4:0]       id_ex_rt;
    logic [4:0]       if_id_rs;
    logic [4:0]       if_id_rt;
    logic [31:0]      pc_out;
    logic             imem_req;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             id_ex_flush;
    logic             ex_mem_flush;
    logic [CNT_W-1:0] stall_cnt;
    modport slave (
        input  imem_ready, branch_taken, branch_target, id_ex_mem_read, id_ex_rt, if_id_rs, if_id_rt,
        output pc_out, imem_req, if_id_write, if_id_flush, id_ex_bubble, id_ex_flush, ex_mem_flush, stall_cnt
    );
    modport master (
        output imem_ready, branch_taken, branch_target, id_ex_mem_read, id_ex_rt, if_id_rs, if_id_rt,
        input  pc_out, imem_req, if_id_write, if_id_flush, id_ex_bubble, id_ex_flush, ex_mem_flush, stall_cnt
    );
endinterface

// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: PC owner and IF-stage sequencer (advance, memory wait, load-use stall, branch redirect)
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input logic          clk,
    input logic          rst,
    if_fetch_ctrl_if.slave bus
);
    typedef enum logic [1:0] {FETCH, WAIT, DRAIN} state_t;
    state_t           state, state_nx;
    logic [31:0]      pc, redir_pc, pc_nx;
    logic [CNT_W-1:0] stall_cnt;
    logic             lu, pc_load, redir_load, drain, br;
    assign lu    = bus.id_ex_mem_read && (bus.id_ex_rt != 5'd0) &&
                   (bus.id_ex_rt == bus.if_id_rs || bus.id_ex_rt == bus.if_id_rt);
    assign drain = (state == DRAIN);
    // A branch seen in DRAIN is ignored: the younger stages were already squashed
    assign br    = !drain && bus.branch_taken;
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            redir_pc  <= 32'h0;
            stall_cnt <= '0;
        end else begin
            state <= state_nx;
            if (pc_load) pc <= pc_nx;
            if (redir_load) redir_pc <= bus.branch_target;
            if (!pc_load && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
    always_comb begin
        state_nx   = state;
        pc_load    = 1'b0;
        pc_nx      = pc;
        redir_load = 1'b0;
        if (drain) begin
            state_nx = bus.imem_ready ? FETCH : DRAIN;
            pc_load  = bus.imem_ready;
            pc_nx    = redir_pc;
        end else if (br) begin
            state_nx   = bus.imem_ready ? FETCH : DRAIN;
            pc_load    = bus.imem_ready;
            pc_nx      = bus.branch_target;
            redir_load = !bus.imem_ready;
        end else if (lu) begin
            state_nx = bus.imem_ready ? FETCH : WAIT;
        end else if (!bus.imem_ready) begin
            state_nx = WAIT;
        end else begin
            state_nx = FETCH;
            pc_load  = 1'b1;
            pc_nx    = pc + 32'd4;
        end
    end
    always_comb begin
        bus.pc_out       = pc;
        bus.stall_cnt    = stall_cnt;
        bus.imem_req     = !rst;
        bus.if_id_write  = !rst && !drain && !br && !lu && bus.imem_ready;
        bus.if_id_flush  = !rst && (drain || br || (!lu && !bus.imem_ready));
        bus.id_ex_bubble = !rst && !drain && !br && lu;
        bus.id_ex_flush  = !rst && br;
        bus.ex_mem_flush = !rst && br;
    end
endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb_if_fetch_ctrl: directed scenarios and random traffic checked against a behavioural fetch model
module tb_if_fetch_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   fails  = 0;
    always #5 clk = ~clk;
    if_fetch_ctrl_if #(.CNT_W(16)) bus ();
    if_fetch_ctrl_if #(.CNT_W(3))  sbus ();
    if_fetch_ctrl #(.RESET_PC(32'h0), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
    if_fetch_ctrl #(.RESET_PC(32'h0), .CNT_W(3))  dut_small (.clk(clk), .rst(rst), .bus(sbus));
    assign sbus.imem_ready     = bus.imem_ready;
    assign sbus.branch_taken   = bus.branch_taken;
    assign sbus.branch_target  = bus.branch_target;
    assign sbus.id_ex_mem_read = bus.id_ex_mem_read;
    assign sbus.id_ex_rt       = bus.id_ex_rt;
    assign sbus.if_id_rs       = bus.if_id_rs;
    assign sbus.if_id_rt       = bus.if_id_rt;
    // Model: fetch address, a pending redirect and an unbounded count of cycles without a PC move
    logic [31:0] m_pc, m_redir;
    bit          m_pending;
    int          m_stalls;
    function automatic bit hazard();
        return bus.id_ex_mem_read && bus.id_ex_rt != 5'd0 &&
               (bus.id_ex_rt == bus.if_id_rs || bus.id_ex_rt == bus.if_id_rt);
    endfunction
    always @(posedge clk) begin
        if (rst) begin
            m_pc = 32'h0; m_redir = 32'h0; m_pending = 0; m_stalls = 0;
        end else if (m_pending) begin
            if (bus.imem_ready) begin m_pc = m_redir; m_pending = 0; end
            else m_stalls++;
        end else if (bus.branch_taken) begin
            if (bus.imem_ready) m_pc = bus.branch_target;
            else begin m_redir = bus.branch_target; m_pending = 1; m_stalls++; end
        end else if (hazard() || !bus.imem_ready) m_stalls++;
        else m_pc = m_pc + 32'd4;
    end
    // {pc, req, write, flush, bubble, id_ex_flush, ex_mem_flush, stall16, stall3}
    function automatic logic [56:0] expv();
        logic [5:0] c;
        c = rst ? 6'b000000 : m_pending ? 6'b101000 : bus.branch_taken ? 6'b101011 :
            hazard() ? 6'b100100 : !bus.imem_ready ? 6'b101000 : 6'b110000;
        return {m_pc, c, (m_stalls > 65535) ? 16'hFFFF : 16'(m_stalls), (m_stalls > 7) ? 3'd7 : 3'(m_stalls)};
    endfunction
    function automatic logic [56:0] actv();
        return {bus.pc_out, bus.imem_req, bus.if_id_write, bus.if_id_flush, bus.id_ex_bubble,
                bus.id_ex_flush, bus.ex_mem_flush, bus.stall_cnt, sbus.stall_cnt};
    endfunction
    task automatic drive(input bit rdy, input bit br, input logic [31:0] tgt, input bit mr,
                         input logic [4:0] ert, input logic [4:0] rs, input logic [4:0] rt);
        bus.imem_ready = rdy; bus.branch_taken = br; bus.branch_target = tgt;
        bus.id_ex_mem_read = mr; bus.id_ex_rt = ert; bus.if_id_rs = rs; bus.if_id_rt = rt;
    endtask
    task automatic do_reset();
        rst = 1'b1;
        drive(1, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask
    task automatic advance(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0);
            @(negedge clk);
        end
    endtask
    task automatic test_reset();
        rst = 1'b1;
        drive(1, 1, 32'h80, 1, 5'd3, 5'd3, 5'd0);
        @(negedge clk);
        #1;
        checks++;
        if (actv() !== expv()) begin fails++; $display("FAIL reset_model act=%h exp=%h", actv(), expv()); end
        checks++;
        if ({bus.pc_out, bus.imem_req, bus.if_id_flush, bus.id_ex_flush, bus.stall_cnt} !== {32'h0, 3'b000, 16'h0}) begin
            fails++; $display("FAIL reset_outputs act pc=%h req=%b flush=%b cnt=%0d exp pc=0 req=0 flush=0 cnt=0",
                              bus.pc_out, bus.imem_req, bus.if_id_flush, bus.stall_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask
    task automatic test_sequential();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0);
            #1;
            checks++;
            if (actv() !== expv() || bus.pc_out !== 32'(4 * i) || bus.if_id_write !== 1'b1) begin
                fails++; $display("FAIL seq[%0d] act=%h exp=%h", i, actv(), expv());
            end
            @(negedge clk);
        end
        checks++;
        if (bus.pc_out !== 32'd16 || bus.stall_cnt !== 16'd0) begin
            fails++; $display("FAIL seq_end act pc=%h cnt=%0d exp pc=10 cnt=0", bus.pc_out, bus.stall_cnt);
        end
    endtask
    task automatic test_load_use();
        do_reset();
        advance(2);
        drive(1, 0, 32'h0, 1, 5'd5, 5'd5, 5'd1);
        #1;
        checks++;
        if (actv() !== expv() || bus.if_id_write !== 1'b0 || bus.id_ex_bubble !== 1'b1 || bus.if_id_flush !== 1'b0) begin
            fails++; $display("FAIL load_use act=%h exp=%h", actv(), expv());
        end
        @(negedge clk);
        checks++;
        if (bus.pc_out !== 32'd8 || bus.stall_cnt !== 16'd1) begin
            fails++; $display("FAIL load_use_hold act pc=%h cnt=%0d exp pc=8 cnt=1", bus.pc_out, bus.stall_cnt);
        end
        drive(1, 0, 32'h0, 1, 5'd0, 5'd0, 5'd0);
        #1;
        checks++;
        if (actv() !== expv() || bus.if_id_write !== 1'b1 || bus.id_ex_bubble !== 1'b0) begin
            fails++; $display("FAIL load_r0 act=%h exp=%h", actv(), expv());
        end
        @(negedge clk);
    endtask
    task automatic test_branch();
        do_reset();
        advance(5);
        drive(1, 1, 32'h100, 0, 5'd0, 5'd0, 5'd0);
        #1;
        checks++;
        if (actv() !== expv() || {bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush, bus.id_ex_bubble} !== 4'b1110) begin
            fails++; $display("FAIL branch act=%h exp=%h", actv(), expv());
        end
        @(negedge clk);
        checks++;
        if (bus.pc_out !== 32'h100) begin fails++; $display("FAIL branch_pc act=%h exp=00000100", bus.pc_out); end
    endtask
    task automatic test_miss_branch();
        do_reset();
        advance(3);
        for (int i = 0; i < 4; i++) begin
            drive(i == 3, i == 1, 32'h40, 0, 5'd0, 5'd0, 5'd0);
            #1;
            checks++;
            if (actv() !== expv() || bus.pc_out !== 32'd12 || bus.if_id_flush !== 1'b1) begin
                fails++; $display("FAIL miss_branch[%0d] act=%h exp=%h", i, actv(), expv());
            end
            @(negedge clk);
        end
        checks++;
        if (bus.pc_out !== 32'h40) begin fails++; $display("FAIL miss_branch_pc act=%h exp=00000040", bus.pc_out); end
    endtask
    task automatic test_combos();
        do_reset();
        advance(1);
        drive(0, 0, 32'h0, 1, 5'd7, 5'd2, 5'd7);
        #1;
        checks++;
        if (actv() !== expv() || {bus.if_id_flush, bus.if_id_write, bus.id_ex_bubble} !== 3'b001) begin
            fails++; $display("FAIL lu_miss act=%h exp=%h", actv(), expv());
        end
        @(negedge clk);
        drive(1, 1, 32'h200, 1, 5'd7, 5'd7, 5'd7);
        #1;
        checks++;
        if (actv() !== expv() || {bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush, bus.id_ex_bubble} !== 4'b1110) begin
            fails++; $display("FAIL lu_branch act=%h exp=%h", actv(), expv());
        end
        @(negedge clk);
    endtask
    task automatic test_reset_drain();
        do_reset();
        advance(2);
        drive(0, 1, 32'h300, 0, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        drive(0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (actv() !== expv() || bus.pc_out !== 32'h0 || bus.stall_cnt !== 16'd0) begin
            fails++; $display("FAIL reset_drain act=%h exp=%h", actv(), expv());
        end
        rst = 1'b0;
        drive(1, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0);
        #1;
        checks++;
        if (actv() !== expv() || bus.if_id_write !== 1'b1) begin
            fails++; $display("FAIL reset_drain_fetch act=%h exp=%h", actv(), expv());
        end
        @(negedge clk);
        checks++;
        if (bus.pc_out !== 32'h4) begin fails++; $display("FAIL reset_drain_pc act=%h exp=00000004", bus.pc_out); end
    endtask
    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0);
            #1;
            checks++;
            if (actv() !== expv()) begin fails++; $display("FAIL sat[%0d] act=%h exp=%h", i, actv(), expv()); end
            @(negedge clk);
        end
        checks++;
        if (sbus.stall_cnt !== 3'd7 || bus.stall_cnt !== 16'd10) begin
            fails++; $display("FAIL sat_end act small=%0d wide=%0d exp small=7 wide=10", sbus.stall_cnt, bus.stall_cnt);
        end
    endtask
    task automatic test_wrap();
        do_reset();
        drive(1, 1, 32'hFFFF_FFFC, 0, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        drive(1, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0);
        #1;
        checks++;
        if (actv() !== expv() || bus.pc_out !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_pre act=%h exp=%h", actv(), expv()); end
        @(negedge clk);
        checks++;
        if (bus.pc_out !== 32'h0) begin fails++; $display("FAIL wrap act=%h exp=00000000", bus.pc_out); end
    endtask
    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 99) < 2);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, $urandom() & 32'hFFFF_FFFC,
                  $urandom_range(0, 2) == 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            #1;
            checks++;
            if (actv() !== expv()) begin fails++; $display("FAIL random[%0d] act=%h exp=%h", i, actv(), expv()); end
            @(negedge clk);
        end
        rst = 1'b0;
    endtask
    initial begin
        drive(1, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0);
        test_reset();
        test_sequential();
        test_load_use();
        test_branch();
        test_miss_branch();
        test_combos();
        test_reset_drain();
        test_saturation();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
